if_id_fetch_buffer: RTL and testbench
=====================================

Name: if_id_fetch_buffer

Overview:
Instruction fetch buffer between the PC register / instruction ROM (IF) and the decode stage (ID).
Captures each fetched {pc, instruction} pair into a small show-ahead FIFO and presents the head to ID with a valid flag.
Decouples ID stalls from fetch and drops wrong-path instructions on branch, interrupt or exception redirect.
Raises a fetch-stall request to the stall controller before it can overflow.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
ADDR_W, 32, pc width
INST_W, 32, instruction width
NOP_INST, 32'h00000000, instruction value driven on id_inst_o while empty

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
fetch_valid_i  in  1  pc_i/inst_i hold a valid fetch this cycle (inst_enable high and stall[0] low)
pc_i  in  ADDR_W  pc of the fetched instruction
inst_i  in  INST_W  instruction read from ROM for pc_i (combinational ROM, same cycle)
flush_i  in  1  redirect: branch taken, interrupt entry or exception entry; discard all contents
id_ready_i  in  1  ID accepts the head entry this cycle (stall[1] low)
id_valid_o  out  1  head entry valid
id_pc_o  out  ADDR_W  pc of head entry
id_inst_o  out  INST_W  instruction of head entry
fetch_stall_o  out  1  request to freeze PC; high when count >= DEPTH-1
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_err_o  out  1  sticky: a valid fetch was dropped while full

Behaviour:
- Reset (reset low, asynchronous): pointers = 0, count = 0, overflow_err_o = 0. Outputs: id_valid_o = 0, id_pc_o = 0, id_inst_o = NOP_INST, fetch_stall_o = 0. Applies mid-operation regardless of clk; storage contents are don't-care.
- Pop: id_valid_o && id_ready_i. Head pointer advances; wraps modulo DEPTH.
- Push: fetch_valid_i && !flush_i && (count < DEPTH || pop). Writes {pc_i, inst_i} at tail; tail wraps modulo DEPTH.
- Full, push and pop in the same cycle: both occur; count unchanged.
- Full, fetch_valid_i high, no pop, no flush: entry dropped; overflow_err_o set. overflow_err_o clears only on reset.
- Flush has priority over push and pop. Next edge: count = 0, head = tail = 0, id_valid_o = 0. The fetch presented in the flush cycle is wrong-path and is discarded. The first post-flush fetch (redirect target) is pushed normally the following cycle.
- Push-to-output latency: 1 cycle. An entry written at edge N is visible on id_*_o after edge N, if it is the head.
- Outputs are driven from the head entry, gated by count != 0.
- Empty: id_valid_o = 0, id_pc_o = 0, id_inst_o = NOP_INST.
- fetch_stall_o is combinational from the registered count (count >= DEPTH-1). It covers the one cycle in which the PC register still advances after the request.
- count_o always equals the number of valid entries, 0..DEPTH.
- FIFO order is strictly preserved; no reordering.

Optional Feature:
IFB_BYPASS_EN.
- Defined: when count == 0, fetch_valid_i = 1 and flush_i = 0, id_valid_o/id_pc_o/id_inst_o follow pc_i/inst_i combinationally in the same cycle. If id_ready_i is also 1, the entry is consumed and not written (count stays 0); otherwise it is written as a normal push. Zero-latency fetch-to-decode when the buffer is empty.
- Undefined: no bypass path; 1-cycle latency always; no combinational path from pc_i/inst_i to outputs.

Test Plan:
- Reset pulse low mid-stream with count = 3 → all outputs at reset values immediately, without waiting for a clk edge; count_o = 0 after release.
- Push pc 0x00,0x04,0x08 with id_ready_i = 1 continuously → id_pc_o = 0x00,0x04,0x08 on consecutive cycles starting 1 cycle after the first push (0 cycles with IFB_BYPASS_EN); count_o ≤ 1 throughout.
- id_ready_i = 0 while pushing 0x10..0x1C → fetch_stall_o rises when count_o = 3. A 5th fetch (0x20) is dropped and overflow_err_o = 1. Raising id_ready_i then pops 0x10,0x14,0x18,0x1C in order.
- Full buffer, fetch_valid_i = 1 and id_ready_i = 1 same cycle → count_o stays 4, head advances by one, new entry appended at tail, overflow_err_o stays 0.
- flush_i with count = 2 and fetch_valid_i = 1 (pc 0x2C) → next cycle count_o = 0, id_valid_o = 0. Target pc 0x80 pushed the next cycle appears as head; 0x2C never appears.
- Wrap-around: 10 pushes/pops with a 2-entry backlog maintained → id_pc_o sequence matches input order across pointer wraps; id_inst_o = NOP_INST whenever empty.

Source files
------------

// File: rtl/if_id_fetch_buffer.sv
// IF->ID show-ahead fetch buffer: queues {pc, inst} pairs, drops wrong-path entries on flush, requests a PC stall before overflow.
// Optional zero-latency bypass when the buffer is empty: define IFB_BYPASS_EN.
module if_id_fetch_buffer #(
    parameter int                 DEPTH    = 4,
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_valid_i,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [INST_W-1:0]        inst_i,
    input  logic                     flush_i,
    input  logic                     id_ready_i,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [INST_W-1:0]        id_inst_o,
    output logic                     fetch_stall_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic empty;
    logic full;
    logic pop_fifo;
    logic push;
    logic bypass_take;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

`ifdef IFB_BYPASS_EN
    logic bypass_act;
    assign bypass_act  = empty && fetch_valid_i && !flush_i;
    // An empty-buffer fetch that ID accepts immediately is consumed without being stored.
    assign bypass_take = bypass_act && id_ready_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign pop_fifo = !empty && id_ready_i && !flush_i;
    assign push     = fetch_valid_i && !flush_i && (!full || pop_fifo) && !bypass_take;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_fifo) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
            if (fetch_valid_i && full && !pop_fifo) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= pc_i;
            inst_mem[tail_q] <= inst_i;
        end
    end

    always_comb begin
        id_valid_o = 1'b0;
        id_pc_o    = '0;
        id_inst_o  = NOP_INST;
        if (!reset) begin
            id_valid_o = 1'b0;
        end else if (!empty) begin
            id_valid_o = 1'b1;
            id_pc_o    = pc_mem[head_q];
            id_inst_o  = inst_mem[head_q];
        end
`ifdef IFB_BYPASS_EN
        else if (bypass_act) begin
            id_valid_o = 1'b1;
            id_pc_o    = pc_i;
            id_inst_o  = inst_i;
        end
`endif
    end

    // Raised one entry early: the PC still advances once after the request.
    assign fetch_stall_o  = (count_q >= CNT_W'(DEPTH - 1));
    assign count_o        = count_q;
    assign overflow_err_o = ovf_q;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Self-checking bench for if_id_fetch_buffer: queue-based reference model compared every negedge, plus literal spot checks.
module tb_if_id_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        flush_i = 1'b0;
    logic        id_ready_i = 1'b0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        fetch_stall_o;
    logic [2:0]  count_o;
    logic        overflow_err_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    if_id_fetch_buffer #(
        .DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .reset(reset), .fetch_valid_i(fetch_valid_i), .pc_i(pc_i),
        .inst_i(inst_i), .flush_i(flush_i), .id_ready_i(id_ready_i),
        .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .fetch_stall_o(fetch_stall_o), .count_o(count_o), .overflow_err_o(overflow_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;

`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue advanced with the rules of the buffer.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
        end else if (flush_i) begin
            q.delete();
        end else begin
            int  n_before;
            bit  popped;
            bit  consumed;
            ent_t e;
            n_before = q.size();
            popped   = (n_before > 0) && id_ready_i;
            consumed = BYP && (n_before == 0) && fetch_valid_i && id_ready_i;
            if (popped) void'(q.pop_front());
            if (fetch_valid_i && !consumed) begin
                if (n_before < DEPTH || popped) begin
                    e.pc = pc_i;
                    e.inst = inst_i;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        e_valid = 1'b0;
        e_pc    = '0;
        e_inst  = NOP;
        if (reset && q.size() > 0) begin
            e_valid = 1'b1;
            e_pc    = q[0].pc;
            e_inst  = q[0].inst;
        end else if (reset && BYP && fetch_valid_i && !flush_i) begin
            e_valid = 1'b1;
            e_pc    = pc_i;
            e_inst  = inst_i;
        end
        chk("valid", 32'(id_valid_o), 32'(e_valid));
        chk("pc", id_pc_o, e_pc);
        chk("inst", id_inst_o, e_inst);
        chk("count", 32'(count_o), (reset ? 32'(q.size()) : 32'd0));
        chk("stall", 32'(fetch_stall_o), 32'(reset && q.size() >= DEPTH - 1));
        chk("ovf", 32'(overflow_err_o), 32'(reset && m_ovf));
    end

    task automatic drive(input bit fv, input logic [31:0] pc, input bit fl, input bit rdy);
        fetch_valid_i = fv;
        pc_i          = pc;
        inst_i        = inst_of(pc);
        flush_i       = fl;
        id_ready_i    = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("lit_rst_count", 32'(count_o), 32'd0);
        chk("lit_rst_inst", id_inst_o, NOP);
        drive(0, 0, 0, 1);

        // Streaming with ID always ready
        for (int i = 0; i < 3; i++) drive(1, 32'(i * 4), 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        // Fill while ID stalled, then simultaneous push/pop while full
        drive(1, 32'h10, 0, 0);
        drive(1, 32'h14, 0, 0);
        drive(1, 32'h18, 0, 0);
        chk("lit_count3", 32'(count_o), 32'd3);
        chk("lit_stall3", 32'(fetch_stall_o), 32'd1);
        drive(1, 32'h1C, 0, 0);
        chk("lit_full", 32'(count_o), 32'd4);
        chk("lit_head10", id_pc_o, 32'h10);
        drive(1, 32'h20, 0, 1);
        chk("lit_fullpp_count", 32'(count_o), 32'd4);
        chk("lit_fullpp_head", id_pc_o, 32'h14);
        chk("lit_fullpp_ovf", 32'(overflow_err_o), 32'd0);
        drive(1, 32'h24, 0, 0);
        chk("lit_drop_ovf", 32'(overflow_err_o), 32'd1);
        chk("lit_drop_count", 32'(count_o), 32'd4);
        drive(0, 0, 0, 1);
        chk("lit_pop_head", id_pc_o, 32'h18);
        repeat (4) drive(0, 0, 0, 1);

        // Flush with two entries and a wrong-path fetch in the flush cycle
        drive(1, 32'h24, 0, 0);
        drive(1, 32'h28, 0, 0);
        drive(1, 32'h2C, 1, 0);
        chk("lit_flush_count", 32'(count_o), 32'd0);
        chk("lit_flush_valid", 32'(id_valid_o), 32'd0);
        drive(1, 32'h80, 0, 0);
        chk("lit_target_head", id_pc_o, 32'h80);
        chk("lit_target_count", 32'(count_o), 32'd1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        // Wrap-around with a two-entry backlog
        drive(1, 32'h100, 0, 0);
        drive(1, 32'h104, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 32'h108 + 32'(i * 4), 0, 1);
        repeat (3) drive(0, 0, 0, 1);

        // Asynchronous reset mid-stream with three entries held
        drive(1, 32'h200, 0, 0);
        drive(1, 32'h204, 0, 0);
        drive(1, 32'h208, 0, 0);
        fetch_valid_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("lit_async_valid", 32'(id_valid_o), 32'd0);
        chk("lit_async_count", 32'(count_o), 32'd0);
        chk("lit_async_stall", 32'(fetch_stall_o), 32'd0);
        chk("lit_async_inst", id_inst_o, NOP);
        chk("lit_async_ovf", 32'(overflow_err_o), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(0, 0, 0, 1);
        chk("lit_post_rst_count", 32'(count_o), 32'd0);
        drive(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
